// File: rtl/preg_alloc_if.sv
// Bundle between the rename/commit side and preg_alloc_ctrl, including the free-list
// alloc/free ports.
interface preg_alloc_if #(
    parameter int unsigned TAG_W = 6,
    parameter int unsigned N_REQ = 2,
    parameter int unsigned N_REL = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_gnt;
    logic [TAG_W-1:0]       req_tag;
    logic                   fl_alloc_req;
    logic                   fl_alloc_gnt;
    logic [TAG_W-1:0]       fl_alloc_tag;
    logic [N_REL-1:0]       rel_valid;
    logic [N_REL*TAG_W-1:0] rel_tag;
    logic                   rel_ready;
    logic                   fl_free_req;
    logic [TAG_W-1:0]       fl_free_tag;
    logic                   fl_full;
    logic                   drain_req;
    logic                   drain_done;
    logic                   alloc_blocked;
    logic                   err_overflow;

    modport master (
        output req_valid, fl_alloc_gnt, fl_alloc_tag, rel_valid, rel_tag, fl_full, drain_req,
        input  req_gnt, req_tag, fl_alloc_req, rel_ready, fl_free_req, fl_free_tag,
               drain_done, alloc_blocked, err_overflow
    );

    modport slave (
        input  req_valid, fl_alloc_gnt, fl_alloc_tag, rel_valid, rel_tag, fl_full, drain_req,
        output req_gnt, req_tag, fl_alloc_req, rel_ready, fl_free_req, fl_free_tag,
               drain_done, alloc_blocked, err_overflow
    );
endinterface

// File: rtl/preg_alloc_ctrl.sv
// Free-list front end: round-robin alloc arbitration, release FIFO draining one tag per
// cycle, and a drain FSM that blocks allocation until all queued releases are freed.
module preg_alloc_ctrl #(
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned N_REL    = 2,
    parameter int unsigned FQ_DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    preg_alloc_if.slave bus
);
    localparam int unsigned RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e           state_q;
    logic             drain_done_q;
    logic             alloc_blocked_q;
    logic             err_overflow_q;
    logic [RR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [TAG_W-1:0] mem_q [FQ_DEPTH];

    logic [RR_W-1:0]  winner;
    logic [RR_W-1:0]  rr_ptr_next;
    logic             grant;
    logic             rel_ready;
    logic             pop;
    logic [CNT_W-1:0] push_cnt;
    logic [N_REL-1:0] wr_en;
    logic [PTR_W-1:0] wr_addr [N_REL];

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        logic             found;
        int unsigned      sum;
        logic [RR_W-1:0]  cand;
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sum  = 32'(rr_ptr_q) + i;
            cand = RR_W'(sum % N_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign bus.fl_alloc_req = (|bus.req_valid) && !alloc_blocked_q;
    assign grant            = bus.fl_alloc_req && bus.fl_alloc_gnt;
    assign bus.req_tag      = bus.fl_alloc_tag;
    assign rr_ptr_next      = (winner == RR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        bus.req_gnt = '0;
        if (grant) bus.req_gnt[winner] = 1'b1;
    end

    assign rel_ready     = (CNT_W'(FQ_DEPTH) - count_q) >= CNT_W'(N_REL);
    assign bus.rel_ready = rel_ready;

    // Valid lanes pack into consecutive slots in ascending lane order.
    always_comb begin
        push_cnt = '0;
        for (int unsigned i = 0; i < N_REL; i++) begin
            wr_addr[i] = wr_ptr_q + PTR_W'(push_cnt);
            wr_en[i]   = rel_ready && bus.rel_valid[i];
            if (wr_en[i]) push_cnt = push_cnt + CNT_W'(1);
        end
    end

    assign pop             = (count_q != '0) && !bus.fl_full;
    assign count_d         = count_q + push_cnt - CNT_W'(pop);
    assign bus.fl_free_req = pop;
    assign bus.fl_free_tag = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_REL; i++) begin
            if (wr_en[i]) mem_q[wr_addr[i]] <= bus.rel_tag[i*TAG_W +: TAG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StRun;
            drain_done_q    <= 1'b0;
            alloc_blocked_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            rr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            if (grant) rr_ptr_q <= rr_ptr_next;
            rd_ptr_q     <= rd_ptr_q + PTR_W'(pop);
            wr_ptr_q     <= wr_ptr_q + PTR_W'(push_cnt);
            count_q      <= count_d;
            // A release arriving while the free list is full means a double free.
            if ((count_q != '0) && bus.fl_full) err_overflow_q <= 1'b1;
            drain_done_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (bus.drain_req) begin
                        state_q         <= StDrain;
                        alloc_blocked_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if ((count_d == '0) && (bus.rel_valid == '0)) begin
                        state_q      <= StDone;
                        drain_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q         <= StRun;
                    alloc_blocked_q <= 1'b0;
                end
                default: begin
                    state_q         <= StRun;
                    alloc_blocked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.drain_done    = drain_done_q;
    assign bus.alloc_blocked = alloc_blocked_q;
    assign bus.err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed plus randomized bench for preg_alloc_ctrl, checked each cycle against a
// queue-based behavioural model.
module tb_preg_alloc_ctrl;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned N_REQ = 2;
    localparam int unsigned N_REL = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    preg_alloc_if #(.TAG_W(TAG_W), .N_REQ(N_REQ), .N_REL(N_REL)) bus ();

    preg_alloc_ctrl #(
        .TAG_W(TAG_W), .N_REQ(N_REQ), .N_REL(N_REL), .FQ_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: 0 = run, 1 = draining, 2 = done pulse.
    int               m_rr;
    int               m_state;
    bit               m_ovf;
    logic [TAG_W-1:0] m_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_state = 0;
        m_ovf = 1'b0;
        m_q.delete();
    endtask

    task automatic tick();
        logic [N_REQ-1:0] e_gnt;
        bit               e_areq, e_free, e_ready;
        int               w;
        @(negedge clk);
        e_areq = (|bus.req_valid) && (m_state == 0);
        w = -1;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (w < 0 && bus.req_valid[(m_rr + k) % N_REQ]) w = (m_rr + k) % N_REQ;
        end
        e_gnt = '0;
        if (e_areq && bus.fl_alloc_gnt) e_gnt[w] = 1'b1;
        e_ready = (int'(DEPTH) - m_q.size()) >= int'(N_REL);
        e_free  = (m_q.size() != 0) && !bus.fl_full;

        check("req_gnt", 32'(bus.req_gnt), 32'(e_gnt));
        check("fl_alloc_req", 32'(bus.fl_alloc_req), 32'(e_areq));
        check("rel_ready", 32'(bus.rel_ready), 32'(e_ready));
        check("fl_free_req", 32'(bus.fl_free_req), 32'(e_free));
        check("alloc_blocked", 32'(bus.alloc_blocked), 32'(m_state != 0));
        check("drain_done", 32'(bus.drain_done), 32'(m_state == 2));
        check("err_overflow", 32'(bus.err_overflow), 32'(m_ovf));
        if (e_gnt != '0) check("req_tag", 32'(bus.req_tag), 32'(bus.fl_alloc_tag));
        if (e_free) check("fl_free_tag", 32'(bus.fl_free_tag), 32'(m_q[0]));

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_gnt != '0) m_rr = (w + 1) % N_REQ;
            if (m_q.size() != 0 && bus.fl_full) m_ovf = 1'b1;
            if (e_free) void'(m_q.pop_front());
            if (e_ready) begin
                for (int i = 0; i < int'(N_REL); i++) begin
                    if (bus.rel_valid[i]) m_q.push_back(bus.rel_tag[i*TAG_W +: TAG_W]);
                end
            end
            case (m_state)
                0: if (bus.drain_req) m_state = 1;
                1: if (m_q.size() == 0 && bus.rel_valid == '0) m_state = 2;
                default: m_state = 0;
            endcase
        end
        #1;
    endtask

    task automatic idle();
        bus.req_valid    = '0;
        bus.fl_alloc_gnt = 1'b1;
        bus.fl_alloc_tag = '0;
        bus.rel_valid    = '0;
        bus.rel_tag      = '0;
        bus.fl_full      = 1'b0;
        bus.drain_req    = 1'b0;
    endtask

    task automatic rel(input logic [N_REL-1:0] v, input logic [TAG_W-1:0] t0,
                       input logic [TAG_W-1:0] t1);
        bus.rel_valid = v;
        bus.rel_tag   = {t1, t0};
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Both lanes requesting: grants alternate, tag follows the free list.
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.fl_alloc_tag = TAG_W'(32 + i);
            tick();
        end
        bus.req_valid = '0;

        // Releases 5/6 then 9 on lane 1 only.
        rel(2'b11, 6'd5, 6'd6);
        tick();
        rel(2'b10, 6'd0, 6'd9);
        tick();
        rel(2'b00, 6'd0, 6'd0);
        repeat (3) tick();

        // Fill the queue with the free list full, then let it drain.
        bus.fl_full = 1'b1;
        rel(2'b11, 6'd1, 6'd2);
        tick();
        rel(2'b11, 6'd3, 6'd4);
        tick();
        rel(2'b00, 6'd0, 6'd0);
        tick();
        bus.fl_full = 1'b0;
        repeat (5) tick();

        // Drain with three queued entries while lane 0 keeps requesting.
        bus.fl_full = 1'b1;
        rel(2'b11, 6'd10, 6'd11);
        tick();
        rel(2'b01, 6'd12, 6'd0);
        tick();
        rel(2'b00, 6'd0, 6'd0);
        bus.fl_full   = 1'b0;
        bus.req_valid = 2'b01;
        bus.drain_req = 1'b1;
        tick();
        bus.drain_req = 1'b0;
        repeat (6) tick();

        // Empty free list: no grant and the pointer holds.
        bus.fl_alloc_gnt = 1'b0;
        repeat (2) tick();
        bus.fl_alloc_gnt = 1'b1;
        bus.req_valid    = 2'b11;
        repeat (3) tick();
        bus.req_valid = '0;

        // Reset in the middle of a drain with two entries queued.
        bus.fl_full = 1'b1;
        rel(2'b11, 6'd20, 6'd21);
        tick();
        rel(2'b00, 6'd0, 6'd0);
        bus.drain_req = 1'b1;
        tick();
        bus.drain_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.fl_full = 1'b0;
        repeat (2) tick();

        // Random traffic; release sources hold while the queue cannot take them.
        for (int n = 0; n < 600; n++) begin
            bus.req_valid    = N_REQ'($urandom_range(0, 3));
            bus.fl_alloc_gnt = ($urandom_range(0, 4) != 0);
            bus.fl_alloc_tag = TAG_W'($urandom);
            bus.fl_full      = ($urandom_range(0, 5) == 0);
            bus.drain_req    = ($urandom_range(0, 15) == 0);
            if ((int'(DEPTH) - m_q.size()) >= int'(N_REL)) begin
                rel(N_REL'($urandom_range(0, 3)), TAG_W'($urandom), TAG_W'($urandom));
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
